// File: rtl/rambuf_upif_arb_if.sv
// CPU access port of the RAM buffer: enable, single-cycle write/read strobes,
// address, write data, read data and ready.
//   master : arbiter side, drives upen/upws/uprs/upa/updi, samples updo/uprdy
//   slave  : buffer side, the reverse
interface rambuf_upif_arb_if #(
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32
);
  logic               upen;
  logic               upws;
  logic               uprs;
  logic [ADDRBIT-1:0] upa;
  logic [WIDTH-1:0]   updi;
  logic [WIDTH-1:0]   updo;
  logic               uprdy;

  modport master (output upen, upws, uprs, upa, updi, input updo, uprdy);
  modport slave  (input upen, upws, uprs, upa, updi, output updo, uprdy);
endinterface

// File: rtl/rambuf_upif_arb.sv
// Four-requester round-robin arbiter/sequencer for the RAM buffer CPU port.
// One access at a time: grant, single-cycle strobe with upen held, wait for
// uprdy (or timeout), then a one-cycle ack/err back to the winner.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_en_i/wr_i     per-requester request level and direction (1=write)
//   req_a_i/req_di_i  packed per-requester address / write data
//   req_ack_o/err_o   one-cycle completion pulse / timeout flag
//   req_do_o          read data, valid with req_ack_o
//   busy_o, gnt_id_o  not-idle flag, current/last granted requester
//   up                buffer CPU port (master side)
//
// state     | meaning
// IDLE      | upen low, pick next requester round-robin from ptr
// ISSUE     | upen high, one-cycle upws/uprs strobe
// WAIT      | upen high, wait for uprdy or TOUT cycles
// RELEASE   | upen low, ack/err to winner, advance pointer
module rambuf_upif_arb #(
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32,
  parameter int TOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_en_i,
  input  logic [3:0]           req_wr_i,
  input  logic [4*ADDRBIT-1:0] req_a_i,
  input  logic [4*WIDTH-1:0]   req_di_i,
  output logic [3:0]           req_ack_o,
  output logic [3:0]           req_err_o,
  output logic [WIDTH-1:0]     req_do_o,
  output logic                 busy_o,
  output logic [1:0]           gnt_id_o,
  rambuf_upif_arb_if.master    up
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  // WAIT cycles run with cnt_q = 0 .. TOUT-1, so the last one times out.
  localparam logic [7:0] TOUT_M1 = 8'(TOUT - 1);

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               wr_q, wr_d;
  logic [ADDRBIT-1:0] upa_q, upa_d;
  logic [WIDTH-1:0]   updi_q, updi_d;
  logic               upen_q, upen_d;
  logic               upws_q, upws_d;
  logic               uprs_q, uprs_d;
  logic [3:0]         ack_q, ack_d;
  logic [3:0]         err_q, err_d;
  logic [WIDTH-1:0]   do_q, do_d;
  logic               busy_q, busy_d;

  logic [1:0]         win;
  logic [1:0]         idx;
  logic               found;
  logic [3:0]         gnt_dec;

  assign gnt_dec = 4'b0001 << gnt_q;

  // First requesting index at or above the pointer, wrapping mod 4.
  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_en_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Outputs are registered, so each *_d is the value for the state being entered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    upa_d   = upa_q;
    updi_d  = updi_q;
    upen_d  = 1'b0;
    upws_d  = 1'b0;
    uprs_d  = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    do_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (|req_en_i) begin
          state_d = S_ISSUE;
          gnt_d   = win;
          wr_d    = req_wr_i[win];
          upa_d   = req_a_i[int'(win)*ADDRBIT +: ADDRBIT];
          updi_d  = req_di_i[int'(win)*WIDTH +: WIDTH];
          upen_d  = 1'b1;
          upws_d  = req_wr_i[win];
          uprs_d  = ~req_wr_i[win];
        end
      end
      S_ISSUE: begin
        // Strobe drops here: a held strobe would re-trigger the buffer.
        state_d = S_WAIT;
        cnt_d   = '0;
        upen_d  = 1'b1;
      end
      S_WAIT: begin
        cnt_d  = cnt_q + 8'd1;
        upen_d = 1'b1;
        if (up.uprdy) begin
          // Ready on the final count still counts as success.
          state_d = S_RELEASE;
          upen_d  = 1'b0;
          ack_d   = gnt_dec;
          do_d    = wr_q ? '0 : up.updo;
        end else if (cnt_q == TOUT_M1) begin
          state_d = S_RELEASE;
          upen_d  = 1'b0;
          ack_d   = gnt_dec;
          err_d   = gnt_dec;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        ptr_d   = gnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      upa_q   <= '0;
      updi_q  <= '0;
      upen_q  <= 1'b0;
      upws_q  <= 1'b0;
      uprs_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      do_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      upa_q   <= upa_d;
      updi_q  <= updi_d;
      upen_q  <= upen_d;
      upws_q  <= upws_d;
      uprs_q  <= uprs_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      do_q    <= do_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ack_o = ack_q;
  assign req_err_o = err_q;
  assign req_do_o  = do_q;
  assign busy_o    = busy_q;
  assign gnt_id_o  = gnt_q;
  assign up.upen   = upen_q;
  assign up.upws   = upws_q;
  assign up.uprs   = uprs_q;
  assign up.upa    = upa_q;
  assign up.updi   = updi_q;

endmodule

// File: tb/tb_rambuf_upif_arb.sv
// Directed bench for rambuf_upif_arb with a small RAM-buffer model whose
// ready latency (dly, 0 = never) is set per test.
module tb_rambuf_upif_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_en, req_wr;
  logic [19:0]  req_a;
  logic [127:0] req_di;
  logic [3:0]   req_ack, req_err;
  logic [31:0]  req_do;
  logic         busy;
  logic [1:0]   gnt_id;

  int n_vec = 0;
  int n_miss = 0;

  rambuf_upif_arb_if #(.ADDRBIT(5), .WIDTH(32)) up_if ();

  rambuf_upif_arb #(.ADDRBIT(5), .WIDTH(32), .TOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_en_i(req_en), .req_wr_i(req_wr), .req_a_i(req_a), .req_di_i(req_di),
    .req_ack_o(req_ack), .req_err_o(req_err), .req_do_o(req_do),
    .busy_o(busy), .gnt_id_o(gnt_id), .up(up_if)
  );

  always #5 clk = ~clk;

  // buffer model
  bit [31:0] mem [32];
  int        dly;
  logic      tb_rdy;
  logic      ld_en;
  logic [4:0] ld_a;
  logic [31:0] ld_d;
  logic      mdl_rdy = 1'b0;
  logic [31:0] mdl_updo = '0;
  int        cd = 0;
  int        n_wr = 0;

  assign up_if.uprdy = mdl_rdy | tb_rdy;
  assign up_if.updo  = mdl_updo;

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    mdl_updo <= mem[up_if.upa];
    mdl_rdy  <= (cd == 1);
    if (rst) cd <= 0;
    else if (up_if.upws || up_if.uprs) begin
      cd <= (dly >= 2) ? dly - 1 : 0;
      if (up_if.upws) begin
        mem[up_if.upa] <= up_if.updi;
        n_wr <= n_wr + 1;
      end
    end else if (cd != 0) cd <= cd - 1;
  end

  // port monitor
  int   n_rs = 0, n_ws = 0, n_dbl = 0, n_ack = 0, n_hi = 0;
  int   low_run = 0, last_gap = 0;
  logic upen_prev = 1'b0, strb_prev = 1'b0;

  always @(posedge clk) begin
    if (up_if.upen) begin
      if (!upen_prev) last_gap <= low_run;
      low_run <= 0;
      n_hi <= n_hi + 1;
    end else low_run <= low_run + 1;
    upen_prev <= up_if.upen;
    if (up_if.uprs) n_rs <= n_rs + 1;
    if (up_if.upws) n_ws <= n_ws + 1;
    if ((up_if.uprs | up_if.upws) && strb_prev) n_dbl <= n_dbl + 1;
    strb_prev <= up_if.uprs | up_if.upws;
    if (|req_ack) n_ack <= n_ack + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [4:0] a, input logic [31:0] d);
    req_wr[i] = wr;
    req_a[i*5 +: 5] = a;
    req_di[i*32 +: 32] = d;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    ld_a = a; ld_d = d; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Returns at the negedge inside the ack cycle; lat counts negedges waited.
  task automatic wait_ack(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (req_ack == 4'b0 && lat < 100);
    chk(tag, {31'b0, |req_ack}, 32'd1);
  endtask

  int lat, rs0, ws0, wr0, hi0, ack0;

  initial begin
    rst = 1'b1; req_en = '0; req_wr = '0; req_a = '0; req_di = '0;
    dly = 2; tb_rdy = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", req_ack, 0);
    chk("rst_err", req_err, 0);
    chk("rst_do", req_do, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_upen", {up_if.upen, up_if.upws, up_if.uprs}, 0);
    chk("rst_upa", up_if.upa, 0);
    chk("rst_updi", up_if.updi, 0);
    rst = 1'b0;
    preload(5'h0A, 32'hDEADBEEF);

    // single read
    set_req(1, 1'b0, 5'h0A, 32'h0);
    rs0 = n_rs; hi0 = n_hi;
    req_en = 4'b0010;
    wait_ack("rd_ack_seen", lat);
    chk("rd_lat", lat, 4);
    chk("rd_ack", req_ack, 4'b0010);
    chk("rd_err", req_err, 0);
    chk("rd_do", req_do, 32'hDEADBEEF);
    chk("rd_gnt", gnt_id, 1);
    chk("rd_upa", up_if.upa, 5'h0A);
    chk("rd_upen_rel", up_if.upen, 0);
    req_en = '0;
    @(negedge clk);
    chk("rd_ack_gone", req_ack, 0);
    chk("rd_busy_idle", busy, 0);
    chk("rd_nrs", n_rs - rs0, 1);
    chk("rd_upen_cycles", n_hi - hi0, 3);

    // single write
    set_req(3, 1'b1, 5'h1F, 32'h12345678);
    ws0 = n_ws; wr0 = n_wr; rs0 = n_rs;
    req_en = 4'b1000;
    wait_ack("wr_ack_seen", lat);
    chk("wr_ack", req_ack, 4'b1000);
    chk("wr_err", req_err, 0);
    chk("wr_do", req_do, 0);
    chk("wr_updi", up_if.updi, 32'h12345678);
    req_en = '0;
    @(negedge clk);
    chk("wr_nws", n_ws - ws0, 1);
    chk("wr_nrs", n_rs - rs0, 0);
    chk("wr_nwrites", n_wr - wr0, 1);
    chk("wr_mem", mem[31], 32'h12345678);

    // round robin from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 5'(i), 32'h0);
    req_en = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr_ack_seen", lat);
      chk("rr_gnt", gnt_id, i);
      chk("rr_ack", req_ack, 4'b0001 << i);
      req_en[i] = 1'b0;
    end
    req_en = 4'b0101;
    wait_ack("rr2_ack_seen", lat);
    chk("rr2_gnt_a", gnt_id, 0);
    req_en[0] = 1'b0;
    wait_ack("rr2_ack_seen", lat);
    chk("rr2_gnt_b", gnt_id, 2);
    req_en[2] = 1'b0;
    @(negedge clk);

    // uprdy while idle is ignored
    tb_rdy = 1'b1;
    @(negedge clk);
    tb_rdy = 1'b0;
    @(negedge clk);
    chk("idle_rdy_busy", busy, 0);
    chk("idle_rdy_ack", req_ack, 0);

    // timeout, buffer never ready
    dly = 0;
    set_req(2, 1'b0, 5'h0A, 32'h0);
    req_en = 4'b0100;
    wait_ack("to_ack_seen", lat);
    chk("to_lat", lat, 10);
    chk("to_ack", req_ack, 4'b0100);
    chk("to_err", req_err, 4'b0100);
    chk("to_do", req_do, 0);
    chk("to_upen_rel", up_if.upen, 0);
    req_en = '0;
    @(negedge clk);
    chk("to_err_gone", req_err, 0);

    // ready one cycle too late still times out
    dly = 9;
    set_req(1, 1'b0, 5'h0A, 32'h0);
    req_en = 4'b0010;
    wait_ack("late_ack_seen", lat);
    chk("late_lat", lat, 10);
    chk("late_err", req_err, 4'b0010);
    req_en = '0;
    @(negedge clk);
    @(negedge clk);
    chk("late_rdy_ignored", req_ack, 0);

    // ready on the final count is success
    dly = 8;
    set_req(3, 1'b0, 5'h0A, 32'h0);
    req_en = 4'b1000;
    wait_ack("edge_ack_seen", lat);
    chk("edge_lat", lat, 10);
    chk("edge_err", req_err, 0);
    chk("edge_do", req_do, 32'hDEADBEEF);
    req_en = '0;
    @(negedge clk);

    // normal access after timeouts, leaves pointer at 1
    dly = 2;
    set_req(0, 1'b0, 5'h0A, 32'h0);
    req_en = 4'b0001;
    wait_ack("post_ack_seen", lat);
    chk("post_lat", lat, 4);
    chk("post_ack", req_ack, 4'b0001);
    chk("post_err", req_err, 0);
    chk("post_do", req_do, 32'hDEADBEEF);
    req_en = '0;
    @(negedge clk);

    // reset mid-WAIT
    set_req(3, 1'b0, 5'h03, 32'h0);
    req_en = 4'b1000;
    @(negedge clk);
    chk("rw_issue_strobe", up_if.uprs, 1);
    @(negedge clk);
    chk("rw_wait_upen", up_if.upen, 1);
    ack0 = n_ack;
    rst = 1'b1;
    req_en = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_upen", up_if.upen, 0);
    chk("rw_strobes", {up_if.upws, up_if.uprs}, 0);
    chk("rw_busy", busy, 0);
    chk("rw_gnt", gnt_id, 0);
    chk("rw_upa", up_if.upa, 0);
    chk("rw_ack", req_ack, 0);
    chk("rw_err", req_err, 0);
    repeat (3) @(negedge clk);
    chk("rw_no_ack", n_ack - ack0, 0);
    req_en = 4'b0011;
    set_req(1, 1'b0, 5'h01, 32'h0);
    wait_ack("rw_ack_seen", lat);
    chk("rw_ptr_gnt", gnt_id, 0);
    req_en = '0;
    @(negedge clk);
    @(negedge clk);

    // back-to-back from one requester
    set_req(1, 1'b0, 5'h0A, 32'h0);
    ack0 = n_dbl;
    req_en = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      rs0 = n_rs;
      wait_ack("b2b_ack_seen", lat);
      chk("b2b_ack", req_ack, 4'b0010);
      chk("b2b_nrs", n_rs - rs0, 1);
      if (k > 0) begin
        chk("b2b_lat", lat, 5);
        chk("b2b_gap", last_gap, 2);
      end
    end
    req_en = '0;
    @(negedge clk);
    chk("b2b_dbl", n_dbl - ack0, 0);
    @(negedge clk);
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
